// File: rtl/credential_entry_ctrl.sv
// credential_entry_ctrl: keypad sequencer for the 4-digit username and
// 4-digit password fed to the unlocker. It issues a one-cycle submit and
// waits for the verdict. It also enforces an inactivity timeout and a lockout
// after repeated failed attempts.
// Optional build macro: CRED_AUTOSUBMIT_EN. When it is defined, storing the
// 8th digit submits automatically and the enter key does nothing.
module credential_entry_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned LOCKOUT_TICKS = 30,
  parameter int unsigned MAX_FAILS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  input  logic       tickEn,
  input  logic       resetCount,
  input  logic       authValid,
  input  logic       authPass,
  output logic [3:0] userNameInput0,
  output logic [3:0] userNameInput1,
  output logic [3:0] userNameInput2,
  output logic [3:0] userNameInput3,
  output logic [3:0] passwordInput0,
  output logic [3:0] passwordInput1,
  output logic [3:0] passwordInput2,
  output logic [3:0] passwordInput3,
  output logic [3:0] inputCount,
  output logic       submit,
  output logic       busy,
  output logic       lockedOut,
  output logic       entryTimeout
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_TICKS + 1);
  localparam int unsigned FAIL_W = 3;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_BACK      = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    USER    = 3'd1,
    PASS    = 3'd2,
    WAIT    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t            state;
  logic [3:0]        slot [8];
  logic [IDLE_W-1:0] idle_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [FAIL_W-1:0] fail_cnt;

  // Digit outputs are the slot registers themselves (0-3 username, 4-7 password)
  assign userNameInput0 = slot[0];
  assign userNameInput1 = slot[1];
  assign userNameInput2 = slot[2];
  assign userNameInput3 = slot[3];
  assign passwordInput0 = slot[4];
  assign passwordInput1 = slot[5];
  assign passwordInput2 = slot[6];
  assign passwordInput3 = slot[7];

  // Entry sequencer: state, slots, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
      inputCount   <= '0;
      submit       <= 1'b0;
      busy         <= 1'b0;
      lockedOut    <= 1'b0;
      entryTimeout <= 1'b0;
      idle_cnt     <= '0;
      lock_cnt     <= '0;
      fail_cnt     <= '0;
    end else begin
      submit       <= 1'b0;
      entryTimeout <= 1'b0;
      case (state)
        IDLE, USER, PASS: begin
          if (resetCount || (keyValid && keyCode == KEY_CLEAR)) begin
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            inputCount <= '0;
            idle_cnt   <= '0;
            state      <= IDLE;
          end else if (keyValid) begin
            // Any key pressed while entering counts as activity, even if it has no effect
            idle_cnt <= '0;
            if (keyCode <= KEY_MAX_DIGIT) begin
              if (inputCount < 4'd8) begin
                slot[inputCount[2:0]] <= keyCode;
                inputCount            <= inputCount + 4'd1;
`ifdef CRED_AUTOSUBMIT_EN
                if (inputCount == 4'd7) begin
                  submit <= 1'b1;
                  busy   <= 1'b1;
                  state  <= WAIT;
                end else
`endif
                state <= (inputCount >= 4'd3) ? PASS : USER;
              end
            end else if (keyCode == KEY_BACK) begin
              if (inputCount != 4'd0) begin
                slot[3'(inputCount - 4'd1)] <= '0;
                inputCount                  <= inputCount - 4'd1;
                if (inputCount == 4'd1)      state <= IDLE;
                else if (inputCount <= 4'd4) state <= USER;
                else                         state <= PASS;
              end
            end else if (keyCode == KEY_ENTER) begin
`ifndef CRED_AUTOSUBMIT_EN
              if (inputCount == 4'd8) begin
                submit <= 1'b1;
                busy   <= 1'b1;
                state  <= WAIT;
              end
`endif
            end
          end else if (tickEn && state != IDLE) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_TICKS - 1)) begin
              for (int i = 0; i < 8; i++) slot[i] <= '0;
              inputCount   <= '0;
              idle_cnt     <= '0;
              entryTimeout <= 1'b1;
              state        <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
        WAIT: begin
          if (resetCount || authValid) begin
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            inputCount <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
            // An abort by resetCount leaves the failure history untouched
            if (!resetCount) begin
              if (authPass) begin
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_cnt + FAIL_W'(1);
                if (fail_cnt + FAIL_W'(1) == FAIL_W'(MAX_FAILS)) begin
                  lock_cnt  <= LOCK_W'(LOCKOUT_TICKS);
                  lockedOut <= 1'b1;
                  state     <= LOCKOUT;
                end
              end
            end
          end
        end
        LOCKOUT: begin
          if (tickEn) begin
            if (lock_cnt <= LOCK_W'(1)) begin
              lock_cnt  <= '0;
              fail_cnt  <= '0;
              lockedOut <= 1'b0;
              state     <= IDLE;
            end else begin
              lock_cnt <= lock_cnt - LOCK_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
